// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the 16-bit IR,
// 32-bit register file datapath. Outputs decode combinationally from the
// timing state and the registered IR.
// Build option: define CU_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT;
// otherwise they retire as NOP.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IROut,
    input  logic        Z,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic [3:0]  RFRegSel,
    output logic [3:0]  RFScrSel,
    output logic [2:0]  RFFunSel,
    output logic [2:0]  RFOutASel,
    output logic [2:0]  RFOutBSel,
    output logic [4:0]  ALUFunSel,
    output logic [2:0]  ARFRegSel,
    output logic [1:0]  ARFFunSel,
    output logic [1:0]  ARFOutCSel,
    output logic [1:0]  ARFOutDSel,
    output logic        DREnable,
    output logic [1:0]  DRFunSel,
    output logic        MemCS,
    output logic        MemWR,
    output logic        IRHighSel,
    output logic        IRWrite,
    output logic        Halted,
    output logic        InstrDone
);

    typedef enum logic [2:0] {
        RST_CLR, F0, F1, DEC, E0, E1, E2, HALT
    } state_t;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_BRA = 6'h01;
    localparam logic [5:0] OP_BNE = 6'h02;
    localparam logic [5:0] OP_LDI = 6'h03;
    localparam logic [5:0] OP_LD  = 6'h04;
    localparam logic [5:0] OP_ST  = 6'h05;
    localparam logic [5:0] OP_ADD = 6'h06;
    localparam logic [5:0] OP_SUB = 6'h07;
    localparam logic [5:0] OP_AND = 6'h08;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [4:0] ALU_PASS = 5'b10000;
    localparam logic [4:0] ALU_ADD  = 5'b10100;
    localparam logic [4:0] ALU_SUB  = 5'b10110;
    localparam logic [4:0] ALU_AND  = 5'b10111;

    state_t     state;
    state_t     state_next;
    logic [5:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] rd_onehot;

    assign opcode    = IROut[15:10];
    assign rd        = IROut[9:8];
    assign rs        = IROut[7:6];
    assign rd_onehot = 4'b0001 << rd;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RST_CLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode from state and IR
    always_comb begin
        state_next = state;
        MuxASel    = 2'b00;
        MuxBSel    = 2'b00;
        MuxCSel    = 2'b00;
        MuxDSel    = 1'b0;
        RFRegSel   = '0;
        RFScrSel   = '0;
        RFFunSel   = 3'b000;
        RFOutASel  = 3'b000;
        RFOutBSel  = 3'b000;
        ALUFunSel  = 5'b00000;
        ARFRegSel  = 3'b000;
        ARFFunSel  = 2'b00;
        ARFOutCSel = 2'b00;
        ARFOutDSel = 2'b00;
        DREnable   = 1'b0;
        DRFunSel   = 2'b00;
        MemCS      = 1'b1;
        MemWR      = 1'b0;
        IRHighSel  = 1'b0;
        IRWrite    = 1'b0;
        Halted     = 1'b0;
        InstrDone  = 1'b0;

        case (state)
            RST_CLR: begin
                ARFRegSel  = 3'b100;
                ARFFunSel  = 2'b11;
                state_next = F0;
            end

            F0, F1: begin
                MemCS      = 1'b0;
                ARFOutDSel = 2'b00;
                IRWrite    = 1'b1;
                IRHighSel  = (state == F1);
                ARFRegSel  = 3'b100;
                ARFFunSel  = 2'b01;
                state_next = (state == F0) ? F1 : DEC;
            end

            DEC: begin
                case (opcode)
                    OP_NOP: begin
                        InstrDone  = 1'b1;
                        state_next = F0;
                    end
                    OP_BRA, OP_BNE, OP_LDI, OP_LD, OP_ST,
                    OP_ADD, OP_SUB, OP_AND: begin
                        state_next = E0;
                    end
                    OP_HLT: begin
                        state_next = HALT;
                    end
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_next = HALT;
`else
                        InstrDone  = 1'b1;
                        state_next = F0;
`endif
                    end
                endcase
            end

            E0: begin
                state_next = F0;
                InstrDone  = 1'b1;
                case (opcode)
                    OP_BRA: begin
                        MuxBSel   = 2'b11;
                        ARFRegSel = 3'b100;
                        ARFFunSel = 2'b10;
                    end
                    OP_BNE: begin
                        if (!Z) begin
                            MuxBSel   = 2'b11;
                            ARFRegSel = 3'b100;
                            ARFFunSel = 2'b10;
                        end
                    end
                    OP_LDI: begin
                        MuxASel  = 2'b11;
                        RFRegSel = rd_onehot;
                        RFFunSel = 3'b010;
                    end
                    OP_LD, OP_ST: begin
                        MuxBSel    = 2'b11;
                        ARFRegSel  = 3'b010;
                        ARFFunSel  = 2'b10;
                        InstrDone  = 1'b0;
                        state_next = E1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        RFOutASel = {1'b0, rd};
                        RFOutBSel = {1'b0, rs};
                        MuxASel   = 2'b00;
                        RFRegSel  = rd_onehot;
                        RFFunSel  = 3'b010;
                        ALUFunSel = (opcode == OP_ADD) ? ALU_ADD :
                                    (opcode == OP_SUB) ? ALU_SUB : ALU_AND;
                    end
                    default: begin
                    end
                endcase
            end

            E1: begin
                MemCS      = 1'b0;
                ARFOutDSel = 2'b10;
                if (opcode == OP_LD) begin
                    DREnable   = 1'b1;
                    DRFunSel   = 2'b01;
                    state_next = E2;
                end else begin
                    RFOutASel  = {1'b0, rd};
                    ALUFunSel  = ALU_PASS;
                    MuxCSel    = 2'b00;
                    MemWR      = 1'b1;
                    InstrDone  = 1'b1;
                    state_next = F0;
                end
            end

            E2: begin
                MuxASel    = 2'b10;
                RFRegSel   = rd_onehot;
                RFFunSel   = 3'b010;
                InstrDone  = 1'b1;
                state_next = F0;
            end

            HALT: begin
                Halted     = 1'b1;
                state_next = HALT;
            end

            default: begin
                state_next = RST_CLR;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed sequence against control_unit with a queue of
// expected per-cycle control words. The bench plays the role of the IR by
// driving IROut with each instruction word directly.
module tb_control_unit;

    typedef struct packed {
        logic [1:0] MuxASel;
        logic [1:0] MuxBSel;
        logic [1:0] MuxCSel;
        logic       MuxDSel;
        logic [3:0] RFRegSel;
        logic [3:0] RFScrSel;
        logic [2:0] RFFunSel;
        logic [2:0] RFOutASel;
        logic [2:0] RFOutBSel;
        logic [4:0] ALUFunSel;
        logic [2:0] ARFRegSel;
        logic [1:0] ARFFunSel;
        logic [1:0] ARFOutCSel;
        logic [1:0] ARFOutDSel;
        logic       DREnable;
        logic [1:0] DRFunSel;
        logic       MemCS;
        logic       MemWR;
        logic       IRHighSel;
        logic       IRWrite;
        logic       Halted;
        logic       InstrDone;
    } cu_vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] IROut;
    logic        Z;

    logic [1:0] MuxASel, MuxBSel, MuxCSel, ARFFunSel, ARFOutCSel, ARFOutDSel, DRFunSel;
    logic       MuxDSel, DREnable, MemCS, MemWR, IRHighSel, IRWrite, Halted, InstrDone;
    logic [3:0] RFRegSel, RFScrSel;
    logic [2:0] RFFunSel, RFOutASel, RFOutBSel, ARFRegSel;
    logic [4:0] ALUFunSel;

    cu_vec_t obs;
    cu_vec_t sb[$];
    int      n_vec  = 0;
    int      n_miss = 0;

    control_unit dut (
        .clock(clock), .reset(reset), .IROut(IROut), .Z(Z),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
        .RFRegSel(RFRegSel), .RFScrSel(RFScrSel), .RFFunSel(RFFunSel),
        .RFOutASel(RFOutASel), .RFOutBSel(RFOutBSel), .ALUFunSel(ALUFunSel),
        .ARFRegSel(ARFRegSel), .ARFFunSel(ARFFunSel),
        .ARFOutCSel(ARFOutCSel), .ARFOutDSel(ARFOutDSel),
        .DREnable(DREnable), .DRFunSel(DRFunSel), .MemCS(MemCS), .MemWR(MemWR),
        .IRHighSel(IRHighSel), .IRWrite(IRWrite), .Halted(Halted), .InstrDone(InstrDone)
    );

    always #5 clock = ~clock;

    assign obs = {MuxASel, MuxBSel, MuxCSel, MuxDSel, RFRegSel, RFScrSel, RFFunSel,
                  RFOutASel, RFOutBSel, ALUFunSel, ARFRegSel, ARFFunSel, ARFOutCSel,
                  ARFOutDSel, DREnable, DRFunSel, MemCS, MemWR, IRHighSel, IRWrite,
                  Halted, InstrDone};

    function automatic cu_vec_t v_idle();
        cu_vec_t v = '0;
        v.MemCS = 1'b1;
        return v;
    endfunction

    function automatic cu_vec_t v_rst();
        cu_vec_t v = v_idle();
        v.ARFRegSel = 3'b100;
        v.ARFFunSel = 2'b11;
        return v;
    endfunction

    function automatic cu_vec_t v_fetch(input logic hi);
        cu_vec_t v = v_idle();
        v.MemCS     = 1'b0;
        v.IRWrite   = 1'b1;
        v.IRHighSel = hi;
        v.ARFRegSel = 3'b100;
        v.ARFFunSel = 2'b01;
        return v;
    endfunction

    function automatic cu_vec_t v_dec(input logic done);
        cu_vec_t v = v_idle();
        v.InstrDone = done;
        return v;
    endfunction

    function automatic cu_vec_t v_arf_imm(input logic [2:0] sel, input logic done);
        cu_vec_t v = v_idle();
        v.MuxBSel   = 2'b11;
        v.ARFRegSel = sel;
        v.ARFFunSel = 2'b10;
        v.InstrDone = done;
        return v;
    endfunction

    function automatic cu_vec_t v_rf_write(input logic [3:0] en, input logic [1:0] src);
        cu_vec_t v = v_idle();
        v.MuxASel   = src;
        v.RFRegSel  = en;
        v.RFFunSel  = 3'b010;
        v.InstrDone = 1'b1;
        return v;
    endfunction

    function automatic cu_vec_t v_alu(input logic [3:0] en, input logic [2:0] a,
                                      input logic [2:0] b, input logic [4:0] fn);
        cu_vec_t v = v_rf_write(en, 2'b00);
        v.RFOutASel = a;
        v.RFOutBSel = b;
        v.ALUFunSel = fn;
        return v;
    endfunction

    function automatic cu_vec_t v_ld_e1();
        cu_vec_t v = v_idle();
        v.MemCS      = 1'b0;
        v.ARFOutDSel = 2'b10;
        v.DREnable   = 1'b1;
        v.DRFunSel   = 2'b01;
        return v;
    endfunction

    function automatic cu_vec_t v_st_e1(input logic [2:0] a);
        cu_vec_t v = v_idle();
        v.MemCS      = 1'b0;
        v.MemWR      = 1'b1;
        v.ARFOutDSel = 2'b10;
        v.RFOutASel  = a;
        v.ALUFunSel  = 5'b10000;
        v.InstrDone  = 1'b1;
        return v;
    endfunction

    function automatic cu_vec_t v_halt();
        cu_vec_t v = v_idle();
        v.Halted = 1'b1;
        return v;
    endfunction

    task automatic push_fetch_dec(input logic done);
        sb.push_back(v_fetch(1'b0));
        sb.push_back(v_fetch(1'b1));
        sb.push_back(v_dec(done));
    endtask

    // Compare one queued word per clock cycle, sampled mid-cycle
    task automatic apply(input string tag);
        cu_vec_t e;
        int      cyc = 0;
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            cyc++;
            n_vec++;
            assert (obs === e) else begin
                n_miss++;
                $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.push_back(v_rst());
        apply(tag);
    endtask

    initial begin
        reset = 1'b1;
        IROut = 16'h0000;
        Z     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        sb.push_back(v_rst());
        apply("reset_hold");
        reset = 1'b0;
        sb.push_back(v_rst());
        apply("reset_release");

        // LDI R2,0x01 then ADD R1,R2: InstrDone on cycles 4 and 8
        IROut = {6'h03, 2'd1, 8'h01};
        push_fetch_dec(1'b0);
        sb.push_back(v_rf_write(4'b0010, 2'b11));
        apply("ldi");
        IROut = {6'h06, 2'd0, 8'h40};
        push_fetch_dec(1'b0);
        sb.push_back(v_alu(4'b0001, 3'b000, 3'b001, 5'b10100));
        apply("add");

        IROut = {6'h07, 2'd3, 8'h80};
        push_fetch_dec(1'b0);
        sb.push_back(v_alu(4'b1000, 3'b011, 3'b010, 5'b10110));
        apply("sub");
        IROut = {6'h08, 2'd2, 8'h00};
        push_fetch_dec(1'b0);
        sb.push_back(v_alu(4'b0100, 3'b010, 3'b000, 5'b10111));
        apply("and");

        // LD R3,0x20 (6 cycles) and ST R3,0x21 (5 cycles)
        IROut = {6'h04, 2'd2, 8'h20};
        push_fetch_dec(1'b0);
        sb.push_back(v_arf_imm(3'b010, 1'b0));
        sb.push_back(v_ld_e1());
        sb.push_back(v_rf_write(4'b0100, 2'b10));
        apply("ld");
        IROut = {6'h05, 2'd2, 8'h21};
        push_fetch_dec(1'b0);
        sb.push_back(v_arf_imm(3'b010, 1'b0));
        sb.push_back(v_st_e1(3'b010));
        apply("st");

        // Branches
        IROut = {6'h01, 2'd0, 8'h10};
        push_fetch_dec(1'b0);
        sb.push_back(v_arf_imm(3'b100, 1'b1));
        apply("bra");
        Z = 1'b1;
        IROut = {6'h02, 2'd0, 8'h10};
        push_fetch_dec(1'b0);
        sb.push_back(v_dec(1'b1));
        apply("bne_z1");
        Z = 1'b0;
        push_fetch_dec(1'b0);
        sb.push_back(v_arf_imm(3'b100, 1'b1));
        apply("bne_z0");

        IROut = 16'h00FF;
        push_fetch_dec(1'b1);
        apply("nop");

        // Reset in the middle of LD abandons it
        IROut = {6'h04, 2'd1, 8'h30};
        push_fetch_dec(1'b0);
        sb.push_back(v_arf_imm(3'b010, 1'b0));
        apply("ld_abort_pre");
        reset = 1'b1;
        sb.push_back(v_ld_e1());
        apply("ld_abort_e1");
        reset = 1'b0;
        sb.push_back(v_rst());
        apply("ld_abort_rst");

        // Undefined opcode 0x20
        IROut = {6'h20, 2'd0, 8'h00};
`ifdef CU_ILLEGAL_TRAP_EN
        push_fetch_dec(1'b0);
        for (int i = 0; i < 3; i++) sb.push_back(v_halt());
        apply("illegal_trap");
        do_reset("illegal_reset");
`else
        push_fetch_dec(1'b1);
        apply("illegal_nop");
`endif

        // HLT is absorbing for 20 cycles even as IROut changes
        IROut = {6'h3F, 2'd0, 8'h00};
        push_fetch_dec(1'b0);
        apply("hlt_dec");
        for (int i = 0; i < 20; i++) sb.push_back(v_halt());
        IROut = {6'h03, 2'd1, 8'h01};
        apply("halt_hold");
        do_reset("halt_reset");
        sb.push_back(v_fetch(1'b0));
        apply("restart_f0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
